// File: rtl/icon_update_ctrl.sv
// Frame-synchronous update controller for the rojobot icon path: stages each
// register-set update and commits it to the icon renderer once per vertical blanking.
module icon_update_ctrl #(
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        upd_sysregs,
  input  logic [7:0]  BotInfo_in,
  input  logic [7:0]  LocX_in,
  input  logic [7:0]  LocY_in,
  input  logic [11:0] pixel_row,
  input  logic        IO_INT_ACK,
  output logic        IO_BotUpdt_Sync,
  output logic [7:0]  BotInfo_reg,
  output logic [7:0]  LocX_reg,
  output logic [7:0]  LocY_reg,
  output logic        frame_commit,
  output logic [1:0]  anim_frame,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned RowW  = 12;
  localparam int unsigned DataW = 8;
  localparam logic [RowW-1:0]  VActiveRow = RowW'(V_ACTIVE);
  localparam logic [DataW-1:0] FrmLast    = DataW'(ANIM_DIV - 1);
  localparam logic [DataW-1:0] DropMax    = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic               commit;
  logic               vblank;
  logic               vblankD;
  logic               vbRise;
  logic               vbFall;
  logic               frmWrap;
  logic               stgValid;
  logic               moved;
  logic [DataW-1:0]   stgInfo;
  logic [DataW-1:0]   stgX;
  logic [DataW-1:0]   stgY;
  logic [DataW-1:0]   frmCnt;

  assign vblank  = (pixel_row >= VActiveRow);
  assign vbRise  = vblank & ~vblankD;
  assign vbFall  = ~vblank & vblankD;
  assign frmWrap = vbRise && (frmCnt == FrmLast);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state and commit decode; at most one commit per blanking interval
  always_comb begin
    stateNext = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (upd_sysregs) stateNext = PENDING;
      end
      PENDING: begin
        if (vblank) begin
          commit    = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (vbFall) stateNext = (stgValid || upd_sysregs) ? PENDING : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Staging, handshake, drop counter and committed register set
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vblankD         <= 1'b0;
      stgValid        <= 1'b0;
      stgInfo         <= '0;
      stgX            <= '0;
      stgY            <= '0;
      drop_cnt        <= '0;
      IO_BotUpdt_Sync <= 1'b0;
      frame_commit    <= 1'b0;
      BotInfo_reg     <= '0;
      LocX_reg        <= '0;
      LocY_reg        <= '0;
    end else begin
      vblankD         <= vblank;
      stgValid        <= upd_sysregs | (stgValid & ~commit);
      IO_BotUpdt_Sync <= upd_sysregs | (IO_BotUpdt_Sync & ~IO_INT_ACK);
      frame_commit    <= commit;
      if (upd_sysregs) begin
        stgInfo <= BotInfo_in;
        stgX    <= LocX_in;
        stgY    <= LocY_in;
      end
      if (upd_sysregs && stgValid && !commit && (drop_cnt != DropMax))
        drop_cnt <= drop_cnt + DataW'(1);
      if (commit) begin
        BotInfo_reg <= stgInfo;
        LocX_reg    <= stgX;
        LocY_reg    <= stgY;
      end
    end
  end

  // Animation: step the frame index once per ANIM_DIV frames if the bot moved
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frmCnt     <= '0;
      anim_frame <= '0;
      moved      <= 1'b0;
    end else begin
      if (vbRise) frmCnt <= frmWrap ? '0 : frmCnt + DataW'(1);
      if (frmWrap) anim_frame <= moved ? anim_frame + 2'd1 : 2'd0;
      // A commit sharing the wrap edge seeds the next window
      if (commit)       moved <= (stgX != LocX_reg) || (stgY != LocY_reg);
      else if (frmWrap) moved <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icon_update_ctrl.sv
// Bench for icon_update_ctrl: directed scenarios plus randomized frames, checked
// every cycle against a behavioural model of the staging/commit/animation rules.
module tb_icon_update_ctrl;

  localparam int unsigned VA = 768;
  localparam int unsigned AD = 2;

  logic        clock;
  logic        reset_n;
  logic        upd_sysregs;
  logic [7:0]  BotInfo_in;
  logic [7:0]  LocX_in;
  logic [7:0]  LocY_in;
  logic [11:0] pixel_row;
  logic        IO_INT_ACK;
  logic        IO_BotUpdt_Sync;
  logic [7:0]  BotInfo_reg;
  logic [7:0]  LocX_reg;
  logic [7:0]  LocY_reg;
  logic        frame_commit;
  logic [1:0]  anim_frame;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mStgInfo, mStgX, mStgY;
  logic [7:0] mInfo, mLocX, mLocY, mDrop;
  logic [1:0] mAnim;
  logic       mStgValid, mDone, mVbD, mMoved, mSync, mFc;
  int         mFrm;

  icon_update_ctrl #(.V_ACTIVE(VA), .ANIM_DIV(AD)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .upd_sysregs    (upd_sysregs),
    .BotInfo_in     (BotInfo_in),
    .LocX_in        (LocX_in),
    .LocY_in        (LocY_in),
    .pixel_row      (pixel_row),
    .IO_INT_ACK     (IO_INT_ACK),
    .IO_BotUpdt_Sync(IO_BotUpdt_Sync),
    .BotInfo_reg    (BotInfo_reg),
    .LocX_reg       (LocX_reg),
    .LocY_reg       (LocY_reg),
    .frame_commit   (frame_commit),
    .anim_frame     (anim_frame),
    .drop_cnt       (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs
  task automatic step(input logic rst, input logic upd, input logic [7:0] info,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [11:0] row, input logic ack);
    bit vb, rise, cmt, wrap, nMoved;
    reset_n = rst; upd_sysregs = upd; BotInfo_in = info; LocX_in = x; LocY_in = y;
    pixel_row = row; IO_INT_ACK = ack;
    @(posedge clock);
    if (!rst) begin
      mStgInfo = 0; mStgX = 0; mStgY = 0; mInfo = 0; mLocX = 0; mLocY = 0;
      mDrop = 0; mAnim = 0; mStgValid = 0; mDone = 0; mVbD = 0; mMoved = 0;
      mSync = 0; mFc = 0; mFrm = 0;
    end else begin
      vb   = (int'(row) >= int'(VA));
      rise = vb && !mVbD;
      cmt  = vb && mStgValid && !mDone;
      wrap = rise && (mFrm == int'(AD) - 1);
      nMoved = mMoved;
      if (wrap) begin
        mAnim  = mMoved ? mAnim + 2'd1 : 2'd0;
        nMoved = 1'b0;
        mFrm   = 0;
      end else if (rise) begin
        mFrm++;
      end
      if (cmt) begin
        nMoved = (mStgX != mLocX) || (mStgY != mLocY);
        mInfo = mStgInfo; mLocX = mStgX; mLocY = mStgY;
      end
      mMoved = nMoved;
      mFc = cmt;
      if (upd && mStgValid && !cmt && mDrop != 8'd255) mDrop = mDrop + 8'd1;
      mStgValid = upd || (mStgValid && !cmt);
      if (upd) begin mStgInfo = info; mStgX = x; mStgY = y; end
      mSync = upd || (mSync && !ack);
      mDone = vb && (mDone || cmt);
      mVbD  = vb;
    end
    #1;
    chk("sync",   32'(IO_BotUpdt_Sync), 32'(mSync));
    chk("info",   32'(BotInfo_reg),     32'(mInfo));
    chk("locx",   32'(LocX_reg),        32'(mLocX));
    chk("locy",   32'(LocY_reg),        32'(mLocY));
    chk("commit", 32'(frame_commit),    32'(mFc));
    chk("anim",   32'(anim_frame),      32'(mAnim));
    chk("drop",   32'(drop_cnt),        32'(mDrop));
  endtask

  task automatic idle(input int n, input logic [11:0] row);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, row, 1'b0);
  endtask

  task automatic upd(input logic [7:0] info, input logic [7:0] x, input logic [7:0] y,
                     input logic [11:0] row);
    step(1'b1, 1'b1, info, x, y, row, 1'b0);
  endtask

  initial begin
    bit saw3;
    reset_n = 1'b0; upd_sysregs = 1'b0; BotInfo_in = '0; LocX_in = '0; LocY_in = '0;
    pixel_row = '0; IO_INT_ACK = 1'b0;

    // Reset with an update pending on the inputs
    step(1'b0, 1'b1, 8'hAA, 8'h55, 8'h33, 12'd800, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 8'h55, 8'h33, 12'd800, 1'b0);
    chk("rst_sync", 32'(IO_BotUpdt_Sync), 32'd0);
    chk("rst_locx", 32'(LocX_reg), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    idle(3, 12'd100);

    // Mid-frame update held until blanking
    upd(8'h02, 8'h10, 8'h20, 12'd100);
    chk("mid_sync", 32'(IO_BotUpdt_Sync), 32'd1);
    idle(3, 12'd100);
    chk("mid_hold_x", 32'(LocX_reg), 32'd0);
    idle(1, 12'd768);
    chk("mid_x",    32'(LocX_reg), 32'h10);
    chk("mid_y",    32'(LocY_reg), 32'h20);
    chk("mid_info", 32'(BotInfo_reg), 32'h02);
    chk("mid_fc",   32'(frame_commit), 32'd1);
    idle(1, 12'd769);
    chk("mid_fc_off", 32'(frame_commit), 32'd0);

    // Overrun within one active frame
    idle(1, 12'd100);
    upd(8'h00, 8'd1, 8'h20, 12'd100);
    upd(8'h00, 8'd2, 8'h20, 12'd100);
    upd(8'h00, 8'd3, 8'h20, 12'd100);
    idle(1, 12'd768);
    chk("ovr_x",    32'(LocX_reg), 32'd3);
    chk("ovr_drop", 32'(drop_cnt), 32'd2);

    // Update during HOLD waits for the next blanking interval
    upd(8'h00, 8'd5, 8'h20, 12'd770);
    idle(2, 12'd771);
    chk("hold_x_same", 32'(LocX_reg), 32'd3);
    idle(3, 12'd100);
    chk("hold_x_active", 32'(LocX_reg), 32'd3);
    idle(1, 12'd768);
    chk("hold_x_next", 32'(LocX_reg), 32'd5);

    // Commit and update on the same edge
    idle(1, 12'd100);
    upd(8'h00, 8'd6, 8'h20, 12'd100);
    upd(8'h00, 8'd7, 8'h20, 12'd768);
    chk("same_old", 32'(LocX_reg), 32'd6);
    idle(1, 12'd769);
    idle(1, 12'd100);
    idle(1, 12'd768);
    chk("same_new", 32'(LocX_reg), 32'd7);
    chk("same_drop", 32'(drop_cnt), 32'd2);

    // Drop counter saturation
    idle(1, 12'd100);
    for (int i = 0; i < 300; i++) upd(8'h01, 8'(i), 8'h20, 12'd100);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    idle(1, 12'd768);
    idle(1, 12'd100);

    // Handshake: set wins over ack
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 12'd100, 1'b1);
    chk("hs_clear", 32'(IO_BotUpdt_Sync), 32'd0);
    step(1'b1, 1'b1, 8'h04, 8'h99, 8'h20, 12'd100, 1'b1);
    chk("hs_set", 32'(IO_BotUpdt_Sync), 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 12'd100, 1'b1);
    chk("hs_ack", 32'(IO_BotUpdt_Sync), 32'd0);

    // Animation with continuous motion, then motion stops
    saw3 = 1'b0;
    for (int f = 0; f < 8; f++) begin
      upd(8'h00, 8'(40 + 7 * f), 8'h20, 12'd100);
      idle(2, 12'd100);
      idle(3, 12'd800);
      if (anim_frame == 2'd3) saw3 = 1'b1;
    end
    chk("anim_reach3", 32'(saw3), 32'd1);
    for (int f = 0; f < 6; f++) begin
      idle(3, 12'd100);
      idle(3, 12'd800);
    end
    chk("anim_stop", 32'(anim_frame), 32'd0);

    // Randomized frames with occasional resets
    for (int f = 0; f < 40; f++) begin
      int act, blk;
      act = int'($urandom_range(3, 40));
      blk = int'($urandom_range(1, 10));
      for (int c = 0; c < act + blk; c++) begin
        step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0),
             8'($urandom), 8'($urandom), 8'($urandom),
             (c < act) ? 12'($urandom_range(0, VA - 1)) : 12'($urandom_range(VA, 4095)),
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icon_update_ctrl.md
# icon_update_ctrl

Frame-synchronous update controller for the rojobot icon path. Captures the rojobot's BotInfo/LocX/LocY register set on every `upd_sysregs` pulse, stages it, and commits it to the icon renderer only during vertical blanking, at most once per frame, so the icon never tears mid-frame. It also owns the CPU update handshake flag (`IO_BotUpdt_Sync` / `IO_INT_ACK`), a dropped-update counter, and a 2-bit animation frame index for the icon bitmaps. It sits between the rojobot/CPU interface and the icon bitmap block, in the pixel clock domain.

## Interface
Parameters:
- `V_ACTIVE`, default 768: first pixel_row value that is vertical blanking.
- `ANIM_DIV`, default 8: frames per animation step; legal range 2..255.

Ports:
- `clock`  in  1  pixel/system clock; all logic on its rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `upd_sysregs`  in  1  one-cycle pulse from the rojobot: new register set is valid this cycle.
- `BotInfo_in`  in  8  rojobot orientation/status; sampled when `upd_sysregs`=1.
- `LocX_in`  in  8  rojobot X location; sampled when `upd_sysregs`=1.
- `LocY_in`  in  8  rojobot Y location; sampled when `upd_sysregs`=1.
- `pixel_row`  in  12  display timing row counter.
- `IO_INT_ACK`  in  1  CPU acknowledge; clears `IO_BotUpdt_Sync`.
- `IO_BotUpdt_Sync`  out  1  level flag to the CPU: an update arrived and is not yet acknowledged.
- `BotInfo_reg`  out  8  committed orientation; drives the icon block.
- `LocX_reg`  out  8  committed X location.
- `LocY_reg`  out  8  committed Y location.
- `frame_commit`  out  1  one-cycle pulse on the cycle after a commit edge.
- `anim_frame`  out  2  icon animation frame index.
- `drop_cnt`  out  8  saturating count of staged updates overwritten before commit.

## Operation
- `vblank` = (`pixel_row` >= `V_ACTIVE`). `vblank_d` is `vblank` registered. `vb_rise` = `vblank` & ~`vblank_d`. `vb_fall` = ~`vblank` & `vblank_d`.
- Staging registers `stg_info`, `stg_x`, `stg_y`: load on every `upd_sysregs`=1, in any state. The latest update wins.
- `stg_valid` is set by `upd_sysregs`. It is cleared by a commit, unless `upd_sysregs` is high in the same cycle; then it stays set.
- Drop count: if `upd_sysregs`=1 while `stg_valid`=1 and no commit occurs that cycle, `drop_cnt` increments. It saturates at 255.
- FSM states:
  - IDLE: nothing staged. Goes to PENDING on `upd_sysregs`.
  - PENDING: staged, waiting for blanking. When `vblank`=1, commit and go to HOLD.
  - HOLD: one commit already done this blanking interval. Stays in HOLD while `vblank`=1. On `vb_fall`, goes to PENDING if `stg_valid` (counting an update in the same cycle), else IDLE.
- Commit edge:
  - `*_reg` ← staging values as they were before this edge. An update in the same cycle stays staged.
  - `moved` ← 1 if the new `LocX`/`LocY` differ from the current `LocX_reg`/`LocY_reg`.
  - `frame_commit`=1 for the next cycle.
- Handshake: `IO_BotUpdt_Sync` is set by `upd_sysregs` and cleared by `IO_INT_ACK`. If both occur in the same cycle, set wins.
- Animation:
  - `frm_cnt` (8 bit) increments on each `vb_rise` and wraps from `ANIM_DIV`-1 to 0.
  - On a wrap with `moved`=1: `anim_frame` ← `anim_frame`+1 (mod 4) and `moved` is cleared.
  - On a wrap with `moved`=0: `anim_frame` ← 0.
  - If a commit and a wrap share an edge, the commit's `moved` value is retained for the next window.
- Reset (`reset_n`=0 at a clock edge) puts all outputs and internal registers to 0 and the FSM to IDLE:
  - `BotInfo_reg`/`LocX_reg`/`LocY_reg`=0, `IO_BotUpdt_Sync`=0, `frame_commit`=0, `anim_frame`=0, `drop_cnt`=0, `stg_valid`=0, `frm_cnt`=0, `vblank_d`=0, `moved`=0.
  - Reset overrides all other inputs, including a commit in progress.

## Timing
- `upd_sysregs` at cycle t: staging registers and `IO_BotUpdt_Sync` are valid at t+1.
- Commit latency: if the FSM is in PENDING at cycle c with `vblank`=1, `*_reg` change at c+1 and `frame_commit` is high during c+1 only.
- Update arriving during HOLD: committed in the next blanking interval, never the current one.
- An update arriving during active video in IDLE reaches the outputs no earlier than the first `vblank` cycle plus 1.
- `*_reg` are guaranteed constant while `vblank`=0.
- `IO_INT_ACK` at cycle t clears the flag at t+1, unless `upd_sysregs` is also high at t.
- `anim_frame` only changes on the cycle after a `vb_rise`.

## Test plan
- Reset: drive `reset_n`=0 for 2 cycles with `upd_sysregs`=1 → all outputs 0 and FSM IDLE after release.
- Update mid-frame: `pixel_row`=100, pulse `upd_sysregs` with info=0x02, X=0x10, Y=0x20 → outputs unchanged until `pixel_row`=768. Then `LocX_reg`=0x10, `LocY_reg`=0x20, `BotInfo_reg`=0x02 one cycle later, and one `frame_commit` pulse.
- Overrun: 3 updates (X=1, 2, 3) during one active frame → commit X=3 and `drop_cnt`=2. With 300 such overwrites → `drop_cnt` holds at 255.
- HOLD: update (X=5) during blanking after that interval's commit → no change until the next blanking interval, then `LocX_reg`=5. Same-cycle commit+update → old value committed, new one stays staged.
- Handshake: `upd_sysregs` and `IO_INT_ACK` in the same cycle → `IO_BotUpdt_Sync`=1. `IO_INT_ACK` alone the next cycle → 0.
- Animation, `ANIM_DIV`=2: X changes every frame → `anim_frame` goes 0→1→2→3→0 every 2 frames. Motion then stops → `anim_frame`=0 at the next wrap.
